// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with transmit FIFO.
// Ports: clk, reset (sync, active-high), tx_data/tx_valid/tx_ready
//   push side, txd serial out (registered, idles high), busy (FSM
//   not idle), fifo_count (queued entries, excludes frame in flight).
module uart_tx_param #(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(STOP_BITS * CLK_DIV);
    localparam int CW = $clog2(DATA_BITS);

    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLK_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP
    } state_t;

    state_t state, state_nx;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [DATA_BITS-1:0] head, shift, shift_nx;
    logic [BW-1:0]        baud;
    logic [CW-1:0]        bitcnt;
    logic                 par, txd_nx;
    logic                 push, pop;
    logic                 bit_end, stop_end;

    assign head     = mem[rptr];
    assign tx_ready = fifo_count != FULL;
    assign push     = tx_valid && tx_ready;
    assign busy     = state != IDLE;
    assign bit_end  = baud == BIT_LAST;
    assign stop_end = baud == STOP_LAST;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        shift_nx = shift;
        txd_nx   = 1'b1;
        unique case (state)
            IDLE: begin
                if (|fifo_count) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end)
                    state_nx = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_nx = shift >> 1;
                    if (bitcnt == DATA_LAST)
                        state_nx = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (bit_end)
                    state_nx = STOP;
            end
            STOP: begin
                if (stop_end) begin
                    if (|fifo_count) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (pop)
            shift_nx = head;
        // txd is registered, so it is driven from the level of the
        // state being entered.
        unique case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shift_nx[0];
            PAR:     txd_nx = par;
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shift  <= '0;
            baud   <= '0;
            bitcnt <= '0;
            par    <= 1'b0;
            txd    <= 1'b1;
        end else begin
            state <= state_nx;
            shift <= shift_nx;
            txd   <= txd_nx;
            if (pop || state == IDLE)
                baud <= '0;
            else if (state == STOP ? stop_end : bit_end)
                baud <= '0;
            else
                baud <= baud + BW'(1);
            if (pop) begin
                bitcnt <= '0;
                par    <= ^head ^ (PARITY == 1);
            end else if (state == DATA && bit_end) begin
                bitcnt <= bitcnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param with four
// framings (8N1, 8E1, 8O1, 7N2) sharing one push stream.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic       rdy_n1, txd_n1, busy_n1;
    logic       rdy_ev, txd_ev, busy_ev;
    logic       rdy_od, txd_od, busy_od;
    logic       rdy_s2, txd_s2, busy_s2;
    logic [2:0] cnt_n1, cnt_ev, cnt_od, cnt_s2;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .reset(reset), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_n1), .txd(txd_n1),
        .busy(busy_n1), .fifo_count(cnt_n1));

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_ev (
        .clk(clk), .reset(reset), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_ev), .txd(txd_ev),
        .busy(busy_ev), .fifo_count(cnt_ev));

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_od (
        .clk(clk), .reset(reset), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_od), .txd(txd_od),
        .busy(busy_od), .fifo_count(cnt_od));

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_s2 (
        .clk(clk), .reset(reset), .tx_data(tx_data[6:0]),
        .tx_valid(tx_valid), .tx_ready(rdy_s2), .txd(txd_s2),
        .busy(busy_s2), .fifo_count(cnt_s2));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            npass++;
    endtask

    // Frame words: bit i is the line level of bit period i
    // (start, data LSB first, parity, stops), padded with idle 1s.
    typedef struct {
        logic [7:0]  d;
        logic [10:0] n1;
        logic [10:0] ev;
        logic [10:0] od;
        logic [10:0] s2;
    } vec_t;

    vec_t tbl [6];

    logic [10:0] g_n1, g_ev, g_od, g_s2;
    int          glitch;
    int          b;
    int          idle_err;

    logic        acc;
    logic        saw_full;
    logic [2:0]  maxc;
    int          v;
    int          nf;
    int          st [6];
    logic [7:0]  fd;
    logic        sb, stp;
    int          w;

    initial begin
        tbl[0] = '{8'hA5, 11'h74A, 11'h54A, 11'h74A, 11'h74A};
        tbl[1] = '{8'h03, 11'h606, 11'h406, 11'h606, 11'h706};
        tbl[2] = '{8'h7F, 11'h6FE, 11'h6FE, 11'h4FE, 11'h7FE};
        tbl[3] = '{8'h00, 11'h600, 11'h400, 11'h600, 11'h700};
        tbl[4] = '{8'h80, 11'h700, 11'h700, 11'h500, 11'h700};
        tbl[5] = '{8'h55, 11'h6AA, 11'h4AA, 11'h6AA, 11'h7AA};

        // Reset with a push offered that must be discarded.
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd_n1, 1);
        chk("rst_busy", busy_n1, 0);
        chk("rst_ready", rdy_n1, 1);
        chk("rst_count", cnt_n1, 0);
        idle_err = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (txd_n1 !== 1'b1 || busy_n1 !== 1'b0 ||
                rdy_n1 !== 1'b1 || cnt_n1 !== 3'd0 ||
                txd_ev !== 1'b1 || txd_od !== 1'b1 ||
                txd_s2 !== 1'b1)
                idle_err++;
        end
        chk("rst_idle100", idle_err, 0);

        // Single frames in all four framings.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            tx_data  = tbl[i].d;
            tx_valid = 1'b1;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            @(negedge clk);
            chk("lat_count1", cnt_n1, 1);
            @(posedge clk);
            glitch = 0;
            g_n1 = '1; g_ev = '1; g_od = '1; g_s2 = '1;
            for (int j = 0; j < 44; j++) begin
                @(negedge clk);
                b = j / 4;
                if (j % 4 == 2) begin
                    g_n1[b] = txd_n1;
                    g_ev[b] = txd_ev;
                    g_od[b] = txd_od;
                    g_s2[b] = txd_s2;
                end
                if (txd_n1 !== tbl[i].n1[b]) glitch++;
                if (txd_ev !== tbl[i].ev[b]) glitch++;
                if (txd_od !== tbl[i].od[b]) glitch++;
                if (txd_s2 !== tbl[i].s2[b]) glitch++;
                if (j == 0) begin
                    chk("start_busy", busy_n1, 1);
                    chk("start_count0", cnt_n1, 0);
                end
                if (j == 39) chk("busy_last_stop", busy_n1, 1);
                if (j == 40) begin
                    chk("busy_fall_n1", busy_n1, 0);
                    chk("busy_fall_7n2", busy_s2, 0);
                end
            end
            chk("frame_8n1", g_n1, tbl[i].n1);
            chk("frame_8e1", g_ev, tbl[i].ev);
            chk("frame_8o1", g_od, tbl[i].od);
            chk("frame_7n2", g_s2, tbl[i].s2);
            chk("level_stable", glitch, 0);
            @(negedge clk);
            chk("busy_fall_par", busy_ev | busy_od, 0);
        end

        // FIFO fill with back-to-back frames on the 8N1 instance.
        repeat (4) @(posedge clk);
        #1;
        saw_full = 1'b0;
        maxc     = '0;
        nf       = 0;
        v        = 1;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        fork
            begin
                while (v <= 6 && cyc < 100000) begin
                    @(negedge clk);
                    acc = rdy_n1;
                    if (!rdy_n1) saw_full = 1'b1;
                    if (cnt_n1 > maxc) maxc = cnt_n1;
                    @(posedge clk);
                    #1;
                    if (acc) begin
                        v++;
                        tx_data = 8'(v * 17);
                    end
                    if (v > 6) tx_valid = 1'b0;
                end
                tx_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    w = 0;
                    @(negedge clk);
                    while (txd_n1 !== 1'b0 && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 400) break;
                    st[f] = cyc;
                    repeat (2) @(negedge clk);
                    sb = txd_n1;
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) @(negedge clk);
                        fd[k] = txd_n1;
                    end
                    repeat (4) @(negedge clk);
                    stp = txd_n1;
                    nf++;
                    chk("fifo_start_bit", sb, 0);
                    chk("fifo_frame_data", fd, 8'(17 * (f + 1)));
                    chk("fifo_stop_bit", stp, 1);
                    if (f > 0)
                        chk("fifo_spacing", st[f] - st[f-1], 40);
                end
            end
        join
        chk("fifo_frames_seen", nf, 6);
        chk("fifo_accepted", v, 7);
        chk("fifo_ready_low", saw_full, 1);
        chk("fifo_max_count", maxc, 4);

        // Reset during data bit 3 of 0x55 with two entries queued.
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h66;
        @(posedge clk);
        #1;
        tx_data = 8'h77;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("mid_count2", cnt_n1, 2);
        chk("mid_bit3", txd_n1, 0);
        chk("mid_busy", busy_n1, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_txd", txd_n1, 1);
        chk("mid_rst_count", cnt_n1, 0);
        chk("mid_rst_busy", busy_n1, 0);
        chk("mid_rst_ready", rdy_n1, 1);
        idle_err = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (txd_n1 !== 1'b1 || busy_n1 !== 1'b0 ||
                txd_ev !== 1'b1 || txd_od !== 1'b1 ||
                txd_s2 !== 1'b1)
                idle_err++;
        end
        chk("mid_rst_quiet", idle_err, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
